// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core front end.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH, WAIT, HOLD} fetch_state_e;

    // Instruction held for decode together with its address.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~32'h3;
    endfunction
endpackage

// File: rtl/cycle_counter.sv
// Free-running cycle counter, cleared by synchronous reset, wraps naturally.
module cycle_counter
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else       count <= count + 1'b1;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads to imem and hands each
// instruction to decode over valid/ready; redirects squash in-flight work.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] cycle
);
    fetch_state_e    state, state_d;
    logic [XLEN-1:0] fetch_pc, fetch_pc_d;
    fetch_pkt_t      held, held_d;
    logic            valid_d;
    logic            discard, discard_d;

    cycle_counter u_cycle (
        .clk   (clk),
        .reset (reset),
        .count (cycle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            held        <= '{pc: RESET_PC, instr: NOP_INSTR};
            instr_valid <= 1'b0;
            discard     <= 1'b0;
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            held        <= held_d;
            instr_valid <= valid_d;
            discard     <= discard_d;
        end
    end

    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        held_d     = held;
        valid_d    = instr_valid;
        discard_d  = discard;
        imem_req   = 1'b0;
        case (state)
            FETCH: begin
                imem_req = !redirect_valid;
                if (redirect_valid) fetch_pc_d = align_pc(redirect_pc);
                else if (imem_gnt)  state_d    = WAIT;
            end
            WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = align_pc(redirect_pc);
                    discard_d  = 1'b1;
                end
                // The response belongs to a stale PC once any redirect has been seen.
                if (imem_rvalid) begin
                    if (discard || redirect_valid) begin
                        discard_d = 1'b0;
                        state_d   = FETCH;
                    end else begin
                        held_d     = '{pc: fetch_pc, instr: imem_rdata};
                        fetch_pc_d = fetch_pc + 32'd4;
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (instr_ready || redirect_valid) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                    if (redirect_valid) fetch_pc_d = align_pc(redirect_pc);
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_addr = fetch_pc;
    assign pc        = held.pc;
    assign instr     = held.instr;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stalls, redirects,
// PC/cycle wrap and reset during an outstanding read.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] pc, instr, cycle;

    // second instance exercising PC wrap from the top of memory
    logic        req2, vld2, rv2;
    logic [31:0] addr2, pc2, instr2, cyc2;
    logic        gnt2 = 1'b1;
    logic [31:0] a2 [2];
    int          n2 = 0;

    int n_cmp = 0, n_err = 0;
    int xfers = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .instr(instr), .cycle(cycle)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
        .imem_rvalid(rv2), .imem_rdata(32'h0000_0013),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(vld2), .instr_ready(1'b1),
        .pc(pc2), .instr(instr2), .cycle(cyc2)
    );

    // one-cycle-latency responder for dut2 (always grants)
    always @(posedge clk) begin
        rv2 <= reset ? 1'b0 : (req2 & gnt2);
        if (!reset && req2 && gnt2) begin
            if (n2 < 2) a2[n2] <= addr2;
            n2 <= n2 + 1;
        end
    end

    always @(posedge clk)
        if (instr_valid && instr_ready) xfers <= xfers + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change 1 time unit after it
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        int x0;
        reset = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
        redirect_valid = 0; redirect_pc = 32'h0; instr_ready = 1'b1;
        cyc; cyc; settle;
        chk("rst_cycle", cycle, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_req", {31'b0, imem_req}, 32'd1);

        reset = 1'b0;
        // sequential fetch at full rate: 0,4,8
        for (int k = 0; k < 3; k++) begin
            settle;
            chk("seq_addr", imem_addr, 32'(4 * k));
            chk("seq_req", {31'b0, imem_req}, 32'd1);
            chk("seq_cycle", cycle, 32'(3 * k));
            imem_gnt = 1;
            cyc;
            imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0093;
            settle;
            chk("seq_wait_req", {31'b0, imem_req}, 32'd0);
            chk("seq_wait_valid", {31'b0, instr_valid}, 32'd0);
            cyc;
            imem_rvalid = 0;
            settle;
            chk("seq_valid", {31'b0, instr_valid}, 32'd1);
            chk("seq_pc", pc, 32'(4 * k));
            chk("seq_instr", instr, 32'h0000_0093);
            cyc;
        end
        settle;
        chk("seq_valid_drop", {31'b0, instr_valid}, 32'd0);
        chk("seq_cycle9", cycle, 32'd9);

        // decode stall: hold for 5 cycles
        imem_gnt = 1; cyc;
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0113; cyc;
        imem_rvalid = 0; instr_ready = 0;
        for (int k = 0; k < 5; k++) begin
            settle;
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_pc", pc, 32'd12);
            chk("stall_instr", instr, 32'h0000_0113);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            cyc;
        end
        instr_ready = 1; cyc; settle;
        chk("stall_done_valid", {31'b0, instr_valid}, 32'd0);
        chk("stall_done_addr", imem_addr, 32'd16);
        chk("stall_done_req", {31'b0, imem_req}, 32'd1);

        // redirect while waiting for a response
        imem_gnt = 1; cyc;
        imem_gnt = 0; redirect_valid = 1; redirect_pc = 32'h0000_0102; settle;
        chk("wait_redir_req", {31'b0, imem_req}, 32'd0);
        cyc;
        redirect_valid = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; cyc;
        imem_rvalid = 0; settle;
        chk("drop_valid", {31'b0, instr_valid}, 32'd0);
        chk("drop_addr", imem_addr, 32'h0000_0100);
        chk("drop_req", {31'b0, imem_req}, 32'd1);
        cyc;
        chk("drop_instr", instr, 32'h0000_0113);

        // redirect in HOLD without transfer squashes
        imem_gnt = 1; cyc;
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0213; cyc;
        imem_rvalid = 0; instr_ready = 0; redirect_valid = 1; redirect_pc = 32'h0000_0200; settle;
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        chk("hold_pc", pc, 32'h0000_0100);
        x0 = xfers;
        cyc;
        redirect_valid = 0; settle;
        chk("squash_valid", {31'b0, instr_valid}, 32'd0);
        chk("squash_xfers", 32'(xfers), 32'(x0));
        chk("squash_addr", imem_addr, 32'h0000_0200);

        // redirect in HOLD with transfer in the same cycle
        imem_gnt = 1; cyc;
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0313; cyc;
        imem_rvalid = 0; instr_ready = 1; redirect_valid = 1; redirect_pc = 32'h0000_0303; settle;
        chk("xr_pc", pc, 32'h0000_0200);
        x0 = xfers;
        cyc;
        redirect_valid = 0; settle;
        chk("xr_xfers", 32'(xfers), 32'(x0 + 1));
        chk("xr_valid", {31'b0, instr_valid}, 32'd0);
        chk("xr_addr", imem_addr, 32'h0000_0300);
        chk("xr_req", {31'b0, imem_req}, 32'd1);

        // PC wrap on the second instance
        chk("wrap_n2", 32'(n2 >= 2), 32'd1);
        chk("wrap_addr0", a2[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", a2[1], 32'h0000_0000);

        // cycle counter wrap
        force dut.u_cycle.count = 32'hFFFF_FFFF;
        settle;
        release dut.u_cycle.count;
        cyc;
        chk("cycle_wrap", cycle, 32'd0);

        // reset during WAIT; stale response after release is ignored
        imem_gnt = 1; cyc;
        imem_gnt = 0; reset = 1; cyc;
        reset = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; settle;
        chk("rw_cycle", cycle, 32'd0);
        chk("rw_req", {31'b0, imem_req}, 32'd1);
        chk("rw_addr", imem_addr, 32'h0);
        cyc;
        imem_rvalid = 0; settle;
        chk("rw_valid", {31'b0, instr_valid}, 32'd0);
        chk("rw_instr", instr, 32'h0000_0013);
        chk("rw_addr2", imem_addr, 32'h0);
        chk("rw_cycle1", cycle, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core: owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, and presents each fetched instruction with its PC on a valid/ready interface to decode. It also maintains the free-running cycle counter that the top level exports as `cycle` alongside `pc` and `instr`. Branch/jump redirects from execute override sequential fetch and squash any in-flight or held instruction.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; held until granted.
- `imem_addr`  out  32  byte address of the fetch; bits [1:0] always 0.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; earliest one cycle after grant; exactly one response per grant.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  execute requests a PC change this cycle.
- `redirect_pc`  in  32  target PC; bits [1:0] ignored (forced to 0).
- `instr_valid`  out  1  `instr`/`pc` hold a fetched instruction.
- `instr_ready`  in  1  decode accepts; transfer when `instr_valid && instr_ready`.
- `pc`  out  32  PC of the presented instruction.
- `instr`  out  32  presented instruction word.
- `cycle`  out  32  cycles since reset deassertion.

## Operation
- Internal `fetch_pc` (next address to fetch); `imem_addr = fetch_pc`.
- States: FETCH, WAIT, HOLD.
- FETCH: `imem_req = !redirect_valid`. On redirect: `fetch_pc <= redirect_pc & ~3`, stay FETCH. Else on `imem_gnt`: go WAIT.
- WAIT: `imem_req = 0`. On redirect: `fetch_pc <= redirect_pc & ~3`, set `discard`. On `imem_rvalid`: if `discard` (or redirect this cycle), drop data, clear `discard`, go FETCH; else `instr <= imem_rdata`, `pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`, `instr_valid <= 1`, go HOLD.
- HOLD: `imem_req = 0`. Transfer (`instr_ready`): `instr_valid <= 0`, go FETCH. Redirect without transfer: instruction squashed, `instr_valid <= 0`, go FETCH. Redirect with transfer: transfer completes, then redirect applied. In both redirect cases `fetch_pc <= redirect_pc & ~3`.
- `fetch_pc + 4` wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- `cycle`: increments by 1 on every edge with `reset = 0`; wraps 32'hFFFF_FFFF -> 0.
- `pc` and `instr` change only on a WAIT->HOLD load; stable while `instr_valid` is high.

## Timing
- Reset values: state FETCH, `fetch_pc = RESET_PC`, `pc = RESET_PC`, `instr = 32'h0000_0013` (NOP), `instr_valid = 0`, `cycle = 0`, `discard = 0`; `imem_req` is 1 in the first cycle after reset deasserts (combinational from FETCH).
- Reset mid-operation: all state returns to reset values next edge; an outstanding memory response arriving after reset is ignored (state FETCH does not sample `imem_rvalid`).
- Best case: grant in cycle N, rvalid in N+1, `instr_valid` high in N+2, ready in N+2, next `imem_req` in N+3 -> one instruction per 3 cycles.
- `instr_valid` is registered; `imem_req` depends combinationally only on state and `redirect_valid`.
- `instr_valid` never drops without a transfer or redirect.

## Structure
- `riscv_pkg`: `XLEN = 32`, `NOP_INSTR = 32'h0000_0013`, `fetch_state_e` enum (FETCH, WAIT, HOLD).
- Sub-module `cycle_counter` (clk, reset, count out 32): natural, reused by top for `cycle`.
- All else in one `always_ff` plus one `always_comb` for next-state/outputs.

## Test plan
- Reset held 2 cycles, memory grants immediately, rdata = 32'h0000_0093 with 1-cycle latency, ready high -> `imem_addr` 0,4,8; `instr_valid` every 3rd cycle; `pc` 0,4,8; `cycle` = 0 during reset, counts 1,2,3... after.
- Decode stalls (ready low 5 cycles) -> `instr_valid`, `pc`, `instr` stable; no `imem_req` until transfer.
- Redirect to 32'h0000_0102 during WAIT, response 32'hDEAD_BEEF arrives -> response dropped, next `imem_addr` = 32'h0000_0100, `instr_valid` never high with DEAD_BEEF.
- Redirect in HOLD with ready low -> `instr_valid` low next cycle; with ready high same cycle -> transfer counted, next fetch at redirect target.
- `RESET_PC = 32'hFFFF_FFFC` -> second fetch address 32'h0000_0000; force `cycle` counter to 32'hFFFF_FFFF -> wraps to 0.
- Assert reset while in WAIT, rvalid arrives 1 cycle after reset release -> ignored, `instr_valid` stays 0, fetch restarts at `RESET_PC`.
